// File: rtl/xy2_100_pkg.sv
// Shared constants and helpers for the XY2-100 galvo transmitter.
package xy2_100_pkg;

  localparam int         XY2_FRAME_BITS = 20;
  localparam int         XY2_BIT_W      = 5;
  localparam logic [2:0] XY2_CTRL       = 3'b001;

  localparam logic LOAD  = 1'b0;
  localparam logic SHIFT = 1'b1;

  // Even parity over the whole frame: control bits contribute a single 1.
  function automatic logic xy2_parity(input logic [15:0] w);
    return 1'b1 ^ (^w);
  endfunction

endpackage

// File: rtl/xy2_100_bit_timer.sv
// Bit/frame timing for XY2-100: clock divider, bit index, CLOCK line and strobes.
import xy2_100_pkg::*;

module xy2_100_bit_timer #(
  parameter int CLK_DIV = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 load,
  output logic                 bit_adv,
  output logic                 frame_end,
  output logic [XY2_BIT_W-1:0] bit_idx,
  output logic                 xy2_clk
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0]        CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]        CNT_HALF = CW'(CLK_DIV / 2);
  localparam logic [XY2_BIT_W-1:0] BIT_LAST = XY2_BIT_W'(XY2_FRAME_BITS - 1);

  logic                 state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [XY2_BIT_W-1:0] bit_nxt;
  logic                 last;

  assign last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= LOAD;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last && bit_idx == BIT_LAST) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    load      = (state == LOAD);
    bit_adv   = (state == SHIFT) && last && (bit_idx != BIT_LAST);
    frame_end = (state == SHIFT) && last && (bit_idx == BIT_LAST);
  end

  // LOAD doubles as cnt=0 of bit 0, so the frame has no idle gap.
  always_comb begin
    cnt_nxt = last ? '0 : cnt + 1'b1;
    bit_nxt = bit_idx;
    if (frame_end)    bit_nxt = '0;
    else if (bit_adv) bit_nxt = bit_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      xy2_clk <= 1'b1;
    end else begin
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      xy2_clk <= (cnt_nxt < CNT_HALF);
    end

endmodule

// File: rtl/xy2_100_tx.sv
// XY2-100 transmitter: pending/active position words and per-axis serialisers.
import xy2_100_pkg::*;

module xy2_100_tx #(
  parameter int          CLK_DIV  = 20,
  parameter logic [15:0] INIT_POS = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in_x,
  input  logic [15:0] data_in_y,
  input  logic        data_en_x,
  input  logic        data_en_y,
  output logic        xy2_clk,
  output logic        xy2_sync,
  output logic        xy2_x,
  output logic        xy2_y,
  output logic        send_end_x,
  output logic        send_end_y
);

  localparam int NUM_AXES = 2;
  localparam logic [XY2_BIT_W-1:0] NEXT_TOP  = XY2_BIT_W'(XY2_FRAME_BITS - 2);

  logic                 load, bit_adv, frame_end;
  logic [XY2_BIT_W-1:0] bit_idx;

  logic [NUM_AXES-1:0][15:0]               din, pend, act;
  logic [NUM_AXES-1:0][XY2_FRAME_BITS-1:0] frame;
  logic [NUM_AXES-1:0]                     den, line;

  xy2_100_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .bit_adv   (bit_adv),
    .frame_end (frame_end),
    .bit_idx   (bit_idx),
    .xy2_clk   (xy2_clk)
  );

  assign din = {data_in_y, data_in_x};
  assign den = {data_en_y, data_en_x};

  // frame[19] is bit 0 on the wire (MSB first).
  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    assign frame[a] = {XY2_CTRL, act[a], xy2_parity(act[a])};
  end

  // Enables on the send_end edge land in pending before LOAD copies it.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int a = 0; a < NUM_AXES; a++) begin
        pend[a] <= INIT_POS;
        act[a]  <= INIT_POS;
        line[a] <= 1'b0;
      end
    end else begin
      for (int a = 0; a < NUM_AXES; a++) begin
        if (den[a]) pend[a] <= din[a];
        if (load)   act[a]  <= pend[a];
        if (frame_end)    line[a] <= XY2_CTRL[2];
        else if (bit_adv) line[a] <= frame[a][NEXT_TOP - bit_idx];
      end
    end

  // SYNC drops only for the parity bit.
  always_ff @(posedge clk or negedge rst)
    if (!rst)         xy2_sync <= 1'b1;
    else if (frame_end) xy2_sync <= 1'b1;
    else if (bit_adv)   xy2_sync <= (bit_idx != NEXT_TOP);

  assign xy2_x      = line[0];
  assign xy2_y      = line[1];
  assign send_end_x = frame_end;
  assign send_end_y = frame_end;

endmodule

// File: doc/xy2_100_tx.md
Name: xy2_100_tx

Overview:
- Serial XY2-100 transmitter for the galvo scanner interface. It sits directly downstream of the motor pace controller.
- Accepts 16-bit X/Y position words with per-axis enables, then continuously serialises 20-bit XY2-100 frames on CLOCK/SYNC/X/Y lines.
- Returns a one-cycle end-of-frame pulse per axis. The upstream stepper paces its increments on this pulse.

Parameters:
- CLK_DIV, 20, system clocks per XY2 bit. Must be even and >= 4. 40 MHz / 20 = 2 MHz bit rate, 100 kHz frame rate.
- INIT_POS, 16'd0, position word held in the pending and active registers after reset.

Ports:
- clk  input  1  system clock, 40 MHz.
- rst  input  1  reset, asynchronous, active-low.
- data_in_x  input  16  new X position word.
- data_in_y  input  16  new Y position word.
- data_en_x  input  1  X word valid; captured on any cycle it is high.
- data_en_y  input  1  Y word valid; captured on any cycle it is high.
- xy2_clk  output  1  XY2 CLOCK line.
- xy2_sync  output  1  XY2 SYNC line.
- xy2_x  output  1  XY2 X data line.
- xy2_y  output  1  XY2 Y data line.
- send_end_x  output  1  one-cycle pulse at end of each X frame.
- send_end_y  output  1  one-cycle pulse at end of each Y frame.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-low.
- Reset values:
  - xy2_clk=1, xy2_sync=1, xy2_x=0, xy2_y=0, send_end_x=0, send_end_y=0.
  - Divider count=0, bit index=0.
  - Pending and active words = INIT_POS.
  - State = LOAD.
- Reset asserted mid-frame aborts the frame immediately; no partial send_end is issued.
- State machine:
  - LOAD: one cycle. Copy pending X/Y words into active shift words, bit index=0, go to SHIFT.
  - SHIFT: run the divider and bits 0..19.
  - After bit 19 completes, go to LOAD.
- Bit timing:
  - Divider cnt counts 0..CLK_DIV-1 and wraps.
  - xy2_clk=1 while cnt < CLK_DIV/2, else 0.
  - Data lines change only on the cycle cnt returns to 0 (the xy2_clk rising edge). The receiver samples on the falling edge.
  - The LOAD cycle is counted as cnt=0 of bit 0, so each frame is exactly 20*CLK_DIV cycles with no gap.
- Frame format per axis, MSB first:
  - Bits 0..2: control 0,0,1.
  - Bits 3..18: data[15:0].
  - Bit 19: even parity, i.e. XOR of bits 0..18 = 1 ^ (^data).
  - xy2_sync=1 for bits 0..18 and 0 for bit 19.
- send_end pulses:
  - send_end_x and send_end_y pulse high together for exactly one cycle, on the cycle cnt=CLK_DIV-1 of bit 19.
  - Both are separate ports because the upstream ORs them; they are always simultaneous.
- Capture:
  - data_en_* high on any cycle writes data_in_* into the pending word on that edge. Last write before LOAD wins.
  - X and Y are captured independently; a word without its enable keeps the old value.
  - Enable high on the send_end cycle: captured into pending and used by the very next LOAD.
  - Enable high on the LOAD cycle or later: captured into pending and used by the following frame.
- Frame repetition: with no enables, the active words repeat indefinitely, because the galvo must see a continuous stream.
- Enable held high continuously: pending is re-captured every cycle. This is legal.

Decomposition:
- Package xy2_100_pkg holds:
  - XY2_FRAME_BITS=20, XY2_CTRL=3'b001.
  - State encoding localparams LOAD/SHIFT.
  - Function xy2_parity(16-bit) returning 1 ^ reduction-XOR.
- Sub-module xy2_100_bit_timer:
  - Owns the divider, bit index, xy2_clk, and the bit_adv and frame_end strobes.
  - The top owns the pending/active registers and per-axis serialisers.

Test Plan:
- Reset release, no enables, CLK_DIV=20 → xy2_x = 0,0,1, sixteen 0s, parity 1; sync low only on bit 19; send_end pulses every 400 cycles; first pulse at cycle 399 after the LOAD cycle.
- Scenario "data_en_x capture":
  - Stimulus: pulse data_en_x with 0x1234 on the send_end cycle.
  - Response: next X frame carries 0x1234, parity 0.
  - Y still sends INIT_POS.
- data_en_x with 0xFFFF held for 3 cycles mid-frame → current frame unchanged; next frame is 0xFFFF, parity 1.
- Two back-to-back enables 0x0001 then 0x8000, both within one frame → only 0x8000 is sent; parity 0.
- Assert rst at bit 10 of a frame → outputs return to reset values within 1 cycle with no send_end; after release a full frame restarts from bit 0.
- Upstream-pacing loop, stepping from 0 to 100 in steps of 30:
  - Stimulus: bench model issues data_en one cycle after each send_end.
  - Response: transmitted X words are 30, 60, 90, 100, then 100 repeated.
